// File: rtl/fir_ctrl_pkg.sv
// Shared types and width helpers for the FIR control blocks.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Products and the TAPS-long sum fit without overflow in this width.
  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_sat.sv
// Arithmetic (floor) right shift of an accumulator followed by saturation
// to a narrower signed output.
module fir_sat #(
  parameter int ACC_W = 20,
  parameter int SHIFT = 8,
  parameter int OUT_W = 13
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] sat_out
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted_s;

  assign shifted_s = acc >>> SHIFT;

  // Clamp the shifted value into the output range.
  always_comb begin
    sat_out = shifted_s[OUT_W-1:0];
    if (shifted_s > MAX_V) begin
      sat_out = MAX_V[OUT_W-1:0];
    end else if (shifted_s < MIN_V) begin
      sat_out = MIN_V[OUT_W-1:0];
    end else begin
      sat_out = shifted_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR: circular delay line, coefficient store and one shared
// MAC stepped across the taps, one tap per cycle.
module fir_mac_sched
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 13,
  parameter int SHIFT  = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic signed [DATA_W-1:0]   din,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic                       coef_we,
  input  logic [clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  output logic                       coef_wr_err,
  output logic signed [OUT_W-1:0]    fir_out,
  output logic                       fir_out_en,
  output logic                       busy
);

  localparam int AW    = clog2(TAPS);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

  state_t                  state_r, state_nxt_s;
  logic [AW-1:0]           wp_r, k_r, tap_idx_s;
  logic signed [ACC_W-1:0] acc_r, prod_s, h_ext_s, x_ext_s;
  logic signed [DATA_W-1:0] x_r [TAPS];
  logic signed [COEF_W-1:0] h_r [TAPS];
  logic signed [OUT_W-1:0] sat_s;
  logic                    take_s, last_tap_s;

  assign busy       = (state_r != IDLE);
  assign din_ready  = ~busy;
  assign take_s     = din_valid & din_ready;
  assign last_tap_s = (k_r == AW'(TAPS-1));
  // Newest sample sits at wp; older samples are found walking backwards.
  assign tap_idx_s  = wp_r - k_r;
  assign h_ext_s    = ACC_W'(h_r[k_r]);
  assign x_ext_s    = ACC_W'(x_r[tap_idx_s]);
  assign prod_s     = h_ext_s * x_ext_s;

  fir_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc     (acc_r),
    .sat_out (sat_s)
  );

  // Next-state decode of the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) state_nxt_s = MAC;
        else        state_nxt_s = IDLE;
      end
      MAC: begin
        if (last_tap_s) state_nxt_s = OUT;
        else            state_nxt_s = MAC;
      end
      OUT:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, delay line, coefficient store, accumulator and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= IDLE;
      wp_r        <= '0;
      k_r         <= '0;
      acc_r       <= '0;
      fir_out     <= '0;
      fir_out_en  <= 1'b0;
      coef_wr_err <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_r[i] <= '0;
        h_r[i] <= '0;
      end
    end else begin
      state_r     <= state_nxt_s;
      fir_out_en  <= 1'b0;
      coef_wr_err <= coef_we & busy;
      if (coef_we && !busy) begin
        h_r[coef_addr] <= coef_wdata;
      end
      case (state_r)
        IDLE: begin
          if (take_s) begin
            x_r[wp_r] <= din;
            k_r       <= '0;
            acc_r     <= '0;
          end
        end
        MAC: begin
          acc_r <= acc_r + prod_s;
          k_r   <= k_r + AW'(1'b1);
        end
        OUT: begin
          fir_out    <= sat_s;
          fir_out_en <= 1'b1;
          wp_r       <= wp_r + AW'(1'b1);
        end
        default: begin
          k_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed self-checking bench for fir_mac_sched; one instance with SHIFT=0 and
// one with SHIFT=8 share all inputs.
module tb_fir_mac_sched;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic              sys_rst;
  logic signed [7:0] din;
  logic              din_valid;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic signed [7:0] coef_wdata;

  logic              rdy0, err0, en0, busy0;
  logic signed [12:0] out0;
  logic              rdy8, err8, en8, busy8;
  logic signed [12:0] out8;

  int errors = 0;
  int checks = 0;

  fir_mac_sched #(.SHIFT(0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_wr_err(err0), .fir_out(out0),
    .fir_out_en(en0), .busy(busy0)
  );

  fir_mac_sched #(.SHIFT(8)) dut8 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy8), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_wr_err(err8), .fir_out(out8),
    .fir_out_en(en8), .busy(busy8)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = 4'(addr);
    coef_wdata = 8'(val);
    tick();
    coef_we = 1'b0;
  endtask

  // Offers one sample (optionally with a same-cycle write to h[0]) and waits for the result.
  task automatic send_sample(input logic signed [7:0] d, input logic we,
                             input logic signed [7:0] wd,
                             output logic signed [12:0] y0,
                             output logic signed [12:0] y8, output int lat);
    din        = d;
    din_valid  = 1'b1;
    coef_we    = we;
    coef_addr  = 4'd0;
    coef_wdata = wd;
    tick();
    din_valid = 1'b0;
    coef_we   = 1'b0;
    lat = -1;
    y0  = 13'sd0;
    y8  = 13'sd0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (en0) begin
        lat = t;
        y0  = out0;
        y8  = out8;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; din = 8'sd0; din_valid = 1'b0;
    coef_we = 1'b0; coef_addr = 4'd0; coef_wdata = 8'sd0;
    tick(); tick();
    sys_rst = 1'b0;
    checks++; if (out0 !== 13'sd0 || out8 !== 13'sd0) begin errors++; $display("FAIL reset_fir_out: got %0d/%0d want 0", out0, out8); end
    checks++; if (en0 !== 1'b0 || en8 !== 1'b0) begin errors++; $display("FAIL reset_fir_out_en: got %b/%b want 0", en0, en8); end
    checks++; if (err0 !== 1'b0 || err8 !== 1'b0) begin errors++; $display("FAIL reset_coef_wr_err: got %b/%b want 0", err0, err8); end
    checks++; if (busy0 !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0", busy0, busy8); end
    checks++; if (rdy0 !== 1'b1 || rdy8 !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b/%b want 1", rdy0, rdy8); end
  endtask

  task automatic test_impulse();
    logic signed [12:0] y0, y8, exp;
    int lat;
    for (int k = 0; k < 16; k++) write_coef(k, k + 1);
    for (int n = 0; n < 18; n++) begin
      send_sample((n == 0) ? 8'sd1 : 8'sd0, 1'b0, 8'sd0, y0, y8, lat);
      exp = (n < 16) ? 13'(n + 1) : 13'sd0;
      checks++;
      if (lat != 17 || y0 !== exp) begin
        errors++;
        $display("FAIL impulse[%0d]: got %0d latency %0d want %0d latency 17", n, y0, lat, exp);
      end
    end
  endtask

  task automatic test_shift();
    logic signed [12:0] y0, y8;
    int lat;
    write_coef(0, 64);
    for (int k = 1; k < 16; k++) write_coef(k, 0);
    send_sample(8'sd100, 1'b0, 8'sd0, y0, y8, lat);
    checks++; if (lat != 17 || y8 !== 13'sd25) begin errors++; $display("FAIL shift8_100: got %0d latency %0d want 25", y8, lat); end
    checks++; if (y0 !== 13'sd4095) begin errors++; $display("FAIL shift0_100_sat: got %0d want 4095", y0); end
    write_coef(0, 1);
    send_sample(8'hFF, 1'b0, 8'sd0, y0, y8, lat);
    checks++; if (lat != 17 || y8 !== -13'sd1) begin errors++; $display("FAIL shift8_floor: got %0d latency %0d want -1", y8, lat); end
    checks++; if (y0 !== -13'sd1) begin errors++; $display("FAIL shift0_neg1: got %0d want -1", y0); end
  endtask

  task automatic test_saturation();
    logic signed [12:0] y0, y8;
    int lat;
    for (int k = 0; k < 16; k++) write_coef(k, 127);
    for (int n = 0; n < 16; n++) send_sample(8'sd127, 1'b0, 8'sd0, y0, y8, lat);
    checks++; if (lat != 17 || y0 !== 13'sd4095) begin errors++; $display("FAIL sat_pos: got %0d latency %0d want 4095", y0, lat); end
    checks++; if (y8 !== 13'sd1008) begin errors++; $display("FAIL sat_pos_shift8: got %0d want 1008", y8); end
    for (int n = 0; n < 16; n++) send_sample(8'h80, 1'b0, 8'sd0, y0, y8, lat);
    checks++; if (lat != 17 || y0 !== -13'sd4096) begin errors++; $display("FAIL sat_neg: got %0d latency %0d want -4096", y0, lat); end
    checks++; if (y8 !== -13'sd1016) begin errors++; $display("FAIL sat_neg_shift8: got %0d want -1016", y8); end
  endtask

  task automatic test_back_to_back();
    int low, en_at, hs_at, drained;
    low = 0; en_at = -1; hs_at = -1; drained = 0;
    din = 8'sd3;
    din_valid = 1'b1;
    tick();
    if (!rdy0) low++;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (en0 && en_at < 0) en_at = t;
      if (rdy0) begin
        hs_at = t + 1;
        break;
      end else begin
        low++;
      end
    end
    tick();
    din_valid = 1'b0;
    checks++; if (en_at != 17) begin errors++; $display("FAIL b2b_en_latency: got %0d want 17", en_at); end
    checks++; if (hs_at != 18) begin errors++; $display("FAIL b2b_next_handshake: got %0d want 18", hs_at); end
    checks++; if (low != 17) begin errors++; $display("FAIL b2b_ready_low: got %0d want 17", low); end
    checks++; if (en0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL b2b_second_taken: got en=%b busy=%b want en=0 busy=1", en0, busy0); end
    for (int t = 0; t < 40; t++) begin
      tick();
      if (en0) begin
        drained = 1;
        break;
      end
    end
    checks++; if (drained != 1) begin errors++; $display("FAIL b2b_drain: got no fir_out_en want one"); end
  endtask

  task automatic test_coef_err();
    logic signed [12:0] y0, y8, got;
    int lat;
    write_coef(0, 7);
    for (int k = 1; k < 16; k++) write_coef(k, 0);
    din = 8'sd1;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick(); tick();
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 8'sd5;
    tick();
    coef_we = 1'b0;
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL coef_err_pulse: got %b want 1", err0); end
    tick();
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL coef_err_one_cycle: got %b want 0", err0); end
    got = 13'sd0;
    for (int t = 0; t < 40; t++) begin
      if (en0) begin
        got = out0;
        break;
      end
      tick();
    end
    checks++; if (got !== 13'sd7) begin errors++; $display("FAIL coef_busy_sample: got %0d want 7", got); end
    send_sample(8'sd1, 1'b0, 8'sd0, y0, y8, lat);
    checks++; if (lat != 17 || y0 !== 13'sd7) begin errors++; $display("FAIL coef_unchanged: got %0d latency %0d want 7", y0, lat); end
    send_sample(8'sd1, 1'b1, 8'sd5, y0, y8, lat);
    checks++; if (lat != 17 || y0 !== 13'sd5) begin errors++; $display("FAIL coef_same_cycle: got %0d latency %0d want 5", y0, lat); end
  endtask

  task automatic test_reset_mid();
    int en_cnt;
    en_cnt = 0;
    for (int k = 0; k < 16; k++) write_coef(k, k + 1);
    din = 8'sd5;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int t = 1; t <= 8; t++) tick();
    sys_rst = 1'b1;
    tick();
    if (en0) en_cnt++;
    tick();
    if (en0) en_cnt++;
    sys_rst = 1'b0;
    checks++; if (out0 !== 13'sd0 || out8 !== 13'sd0) begin errors++; $display("FAIL midrst_fir_out: got %0d/%0d want 0", out0, out8); end
    checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL midrst_state: got busy=%b ready=%b want busy=0 ready=1", busy0, rdy0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL midrst_coef_wr_err: got %b want 0", err0); end
    for (int t = 0; t < 25; t++) begin
      tick();
      if (en0) en_cnt++;
    end
    checks++; if (en_cnt != 0) begin errors++; $display("FAIL midrst_no_output: got %0d strobes want 0", en_cnt); end
    checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL midrst_idle_after: got busy=%b ready=%b want busy=0 ready=1", busy0, rdy0); end
    test_impulse();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_shift();
    test_saturation();
    test_back_to_back();
    test_coef_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
